// File: rtl/apb_master_pkg.sv
// Shared types and defaults for the APB initiator: state encoding, default bus widths
// and the wait-counter width.
package apb_master_pkg;

  localparam int unsigned APB_ADDR_W = 32;
  localparam int unsigned APB_DATA_W = 32;
  localparam int unsigned CNT_W      = 8;

  // 2'd3 is unused; the FSM steers it back to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_ACCESS  = 2'd2,
    ST_ILLEGAL = 2'd3
  } apb_state_e;

  // True on the last ACCESS cycle a target may stall before the transfer is aborted.
  function automatic logic wait_expired(input logic [CNT_W-1:0] cnt, input int unsigned limit);
    return cnt == CNT_W'(limit - 1);
  endfunction

endpackage

// File: rtl/apb_master.sv
// APB initiator: turns single valid/ready commands into SETUP/ACCESS transfers and
// reports read data and error status on a one-cycle response pulse.
module apb_master
  import apb_master_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = APB_ADDR_W,
  parameter int unsigned DATA_WIDTH = APB_DATA_W,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  PSELx,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  apb_state_e            state_q;
  apb_state_e            state_d;
  logic [CNT_W-1:0]      wait_cnt_q;
  logic [CNT_W-1:0]      wait_cnt_d;
  logic                  psel_d;
  logic                  penable_d;
  logic                  pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_d;
  logic                  rsp_valid_d;
  logic                  rsp_err_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_d;
  logic                  accept;
  logic                  timeout_hit;

  // Reset is active-high here; no command is taken while it is asserted.
  assign cmd_ready   = (state_q == ST_IDLE) && !PRESETn;
  assign accept      = cmd_valid && cmd_ready;
  assign timeout_hit = wait_expired(wait_cnt_q, TIMEOUT);

  // State and output registers
  always_ff @(posedge PCLK) begin
    if (PRESETn) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      PSELx      <= 1'b0;
      PENABLE    <= 1'b0;
      PWRITE     <= 1'b0;
      PADDR      <= '0;
      PWDATA     <= '0;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_rdata  <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      PSELx      <= psel_d;
      PENABLE    <= penable_d;
      PWRITE     <= pwrite_d;
      PADDR      <= paddr_d;
      PWDATA     <= pwdata_d;
      rsp_valid  <= rsp_valid_d;
      rsp_err    <= rsp_err_d;
      rsp_rdata  <= rsp_rdata_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_SETUP;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: if (PREADY || timeout_hit) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered bus and response outputs
  always_comb begin
    wait_cnt_d  = wait_cnt_q;
    psel_d      = PSELx;
    penable_d   = PENABLE;
    pwrite_d    = PWRITE;
    paddr_d     = PADDR;
    pwdata_d    = PWDATA;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err;
    rsp_rdata_d = rsp_rdata;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          paddr_d  = cmd_addr;
          pwrite_d = cmd_write;
          pwdata_d = cmd_wdata;
          psel_d   = 1'b1;
        end
      end
      ST_SETUP: begin
        penable_d  = 1'b1;
        wait_cnt_d = '0;
      end
      ST_ACCESS: begin
        if (PREADY) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = PSLVERR;
          rsp_rdata_d = PWRITE ? '0 : PRDATA;
        end else if (timeout_hit) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: a behavioural APB target (memory, stuck, error stub), a bus
// protocol monitor, table vectors, corner sequences and a randomized model comparison.
module tb_apb_master;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 16;

  logic          PCLK = 1'b0;
  logic          PRESETn = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          PSELx;
  logic          PENABLE;
  logic          PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA = '0;
  logic          PREADY = 1'b0;
  logic          PSLVERR = 1'b0;

  always #5 PCLK = ~PCLK;

  apb_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Target model: 0 = memory with registered PREADY and programmable waits,
  // 1 = PREADY stuck low, 2 = always ready with error and fixed read data.
  int          slave_mode = 0;
  int          slave_waits = 0;
  int          wcnt = 0;
  logic [31:0] smem [256] = '{default: '0};

  always @(posedge PCLK) begin
    case (slave_mode)
      1: begin PREADY <= 1'b0; PSLVERR <= 1'b0; end
      2: begin PREADY <= 1'b1; PSLVERR <= 1'b1; PRDATA <= 32'h1234; end
      default: begin
        if (PSELx && PENABLE && !PREADY) begin
          if (wcnt >= slave_waits) begin
            PREADY  <= 1'b1;
            PSLVERR <= (PADDR[7:0] >= 8'hF0);
            if (PWRITE) smem[PADDR[7:0]] <= PWDATA;
            else        PRDATA <= smem[PADDR[7:0]];
            wcnt <= 0;
          end else begin
            wcnt <= wcnt + 1;
          end
        end else begin
          PREADY  <= 1'b0;
          PSLVERR <= 1'b0;
          wcnt    <= 0;
        end
      end
    endcase
  end

  // Protocol monitor
  logic          prev_rst = 1'b1;
  logic          prev_psel = 1'b0;
  logic          prev_pen = 1'b0;
  logic          prev_rv = 1'b0;
  logic          prev_write = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [DW-1:0] prev_wdata = '0;

  task automatic mon_fail(input string name);
    miscompares++;
    $display("FAIL %s: protocol rule broken, got PSELx=%0b PENABLE=%0b rsp_valid=%0b (t=%0t)",
             name, PSELx, PENABLE, rsp_valid, $time);
  endtask

  always @(negedge PCLK) begin
    if (!PRESETn && !prev_rst) begin
      if (PENABLE && !PSELx) mon_fail("penable_without_psel");
      if (PENABLE && !prev_pen && !prev_psel) mon_fail("penable_without_setup");
      if (prev_psel && !prev_pen && !PENABLE) mon_fail("setup_not_one_cycle");
      if (prev_psel && PSELx &&
          (PADDR !== prev_addr || PWRITE !== prev_write || PWDATA !== prev_wdata))
        mon_fail("bus_unstable");
      if (prev_rv && rsp_valid) mon_fail("rsp_valid_width");
    end
    prev_rst   = PRESETn;
    prev_psel  = PSELx;
    prev_pen   = PENABLE;
    prev_rv    = rsp_valid;
    prev_write = PWRITE;
    prev_addr  = PADDR;
    prev_wdata = PWDATA;
  end

  // One command, called at a negedge; returns latency (edges from accept) and result.
  task automatic do_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input int waits, output int lat, output int pen_cycles,
                         output logic err, output logic [31:0] rdata);
    slave_waits = waits;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    check("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    @(posedge PCLK);
    @(negedge PCLK);
    cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom;
    lat = -1; pen_cycles = 0; err = 1'bx; rdata = 'x;
    for (int k = 0; k < 300; k++) begin
      if (k == 0) begin
        check("setup_psel", 64'({PSELx, PENABLE}), 64'b10);
        check("setup_paddr", 64'(PADDR), 64'(a));
        check("setup_pwrite", 64'(PWRITE), 64'(w));
      end
      if (PENABLE) pen_cycles++;
      if (rsp_valid) begin lat = k; break; end
      @(negedge PCLK);
    end
    if (lat >= 0) begin
      err = rsp_err; rdata = rsp_rdata;
      check("psel_low_at_rsp", 64'({PSELx, PENABLE}), 64'b00);
      @(negedge PCLK);
      check("rsp_pulse_width", 64'(rsp_valid), 64'd0);
      check("rsp_rdata_hold", 64'(rsp_rdata), 64'(rdata));
      check("rsp_err_hold", 64'(rsp_err), 64'(err));
    end
  endtask

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    int          waits;
    int          exp_lat;
    int          exp_pen;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t        tbl [8];
  logic [31:0] ref_mem [int unsigned];

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  int          lat;
  int          pen;
  logic        err;
  logic [31:0] rdata;

  initial begin
    // Reset state
    repeat (3) @(negedge PCLK);
    check("rst_bus", 64'({PSELx, PENABLE, PWRITE}), 64'd0);
    check("rst_paddr", 64'(PADDR), 64'd0);
    check("rst_pwdata", 64'(PWDATA), 64'd0);
    check("rst_rsp", 64'({rsp_valid, rsp_err}), 64'd0);
    check("rst_rdata", 64'(rsp_rdata), 64'd0);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    PRESETn = 1'b0;
    #1 check("cmd_ready_after_rst", 64'(cmd_ready), 64'd1);
    @(negedge PCLK);

    tbl[0] = '{1'b1, 32'h5,  32'hDEADBEEF, 0, 3, 2, 1'b0, 32'h0};
    tbl[1] = '{1'b0, 32'h5,  32'h0,        0, 3, 2, 1'b0, 32'hDEADBEEF};
    tbl[2] = '{1'b1, 32'hF4, 32'hCAFE0001, 2, 5, 4, 1'b1, 32'h0};
    tbl[3] = '{1'b0, 32'hF4, 32'h0,        1, 4, 3, 1'b1, 32'hCAFE0001};
    tbl[4] = '{1'b0, 32'h9,  32'h0,        0, 3, 2, 1'b0, 32'h0};
    tbl[5] = '{1'b1, 32'h9,  32'h0000A5A5, 3, 6, 5, 1'b0, 32'h0};
    tbl[6] = '{1'b0, 32'h9,  32'h0,        0, 3, 2, 1'b0, 32'h0000A5A5};
    tbl[7] = '{1'b0, 32'h5,  32'h0,        4, 7, 6, 1'b0, 32'hDEADBEEF};

    for (int i = 0; i < 8; i++) begin
      do_xfer(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].waits, lat, pen, err, rdata);
      check($sformatf("tbl%0d_latency", i), 64'(lat), 64'(tbl[i].exp_lat));
      check($sformatf("tbl%0d_access_cycles", i), 64'(pen), 64'(tbl[i].exp_pen));
      check($sformatf("tbl%0d_err", i), 64'(err), 64'(tbl[i].exp_err));
      check($sformatf("tbl%0d_rdata", i), 64'(rdata), 64'(tbl[i].exp_rdata));
      if (tbl[i].w) ref_mem[tbl[i].a] = tbl[i].d;
    end

    // Stuck target: abort after TO ACCESS cycles
    slave_mode = 1;
    repeat (2) @(negedge PCLK);
    do_xfer(1'b0, 32'h40, 32'h0, 0, lat, pen, err, rdata);
    check("timeout_latency", 64'(lat), 64'(1 + TO));
    check("timeout_access_cycles", 64'(pen), 64'(TO));
    check("timeout_err", 64'(err), 64'd1);
    check("timeout_rdata", 64'(rdata), 64'd0);

    // Error stub, always ready
    slave_mode = 2;
    repeat (2) @(negedge PCLK);
    do_xfer(1'b1, 32'h44, 32'h55AA55AA, 0, lat, pen, err, rdata);
    check("stub_wr_latency", 64'(lat), 64'd2);
    check("stub_wr_err", 64'(err), 64'd1);
    check("stub_wr_rdata", 64'(rdata), 64'd0);
    do_xfer(1'b0, 32'h44, 32'h0, 0, lat, pen, err, rdata);
    check("stub_rd_latency", 64'(lat), 64'd2);
    check("stub_rd_access_cycles", 64'(pen), 64'd1);
    check("stub_rd_err", 64'(err), 64'd1);
    check("stub_rd_rdata", 64'(rdata), 64'h1234);

    // Reset during ACCESS
    slave_mode = 1;
    repeat (2) @(negedge PCLK);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h7; cmd_wdata = 32'h77;
    @(posedge PCLK);
    @(negedge PCLK);
    cmd_valid = 1'b0;
    @(negedge PCLK);
    @(negedge PCLK);
    check("pre_reset_in_access", 64'({PSELx, PENABLE}), 64'b11);
    PRESETn = 1'b1;
    @(negedge PCLK);
    check("mid_reset_bus_idle", 64'({PSELx, PENABLE}), 64'b00);
    check("mid_reset_no_rsp", 64'(rsp_valid), 64'd0);
    check("mid_reset_rsp_cleared", 64'({rsp_err, rsp_rdata}), 64'd0);
    check("mid_reset_cmd_ready", 64'(cmd_ready), 64'd0);
    PRESETn = 1'b0;
    #1 check("post_reset_cmd_ready", 64'(cmd_ready), 64'd1);
    begin
      int rv_seen = 0;
      for (int k = 0; k < 20; k++) begin
        @(negedge PCLK);
        if (rsp_valid) rv_seen++;
      end
      check("aborted_no_rsp", 64'(rv_seen), 64'd0);
    end
    slave_mode = 0;
    repeat (2) @(negedge PCLK);

    // cmd_valid held across six back-to-back commands
    begin
      logic        hw [6];
      logic [31:0] ha [6];
      logic [31:0] hd [6];
      int          acc = 0;
      int          nrsp = 0;
      logic        will;
      for (int i = 0; i < 6; i++) begin
        hw[i] = (i < 3);
        ha[i] = 32'((i % 3) + 1);
        hd[i] = $urandom;
      end
      for (int i = 0; i < 3; i++) hd[i + 3] = hd[i];
      slave_waits = 1;
      cmd_valid = 1'b1; cmd_write = hw[0]; cmd_addr = ha[0]; cmd_wdata = hd[0];
      for (int cyc = 0; cyc < 200 && nrsp < 6; cyc++) begin
        will = cmd_valid && cmd_ready;
        @(posedge PCLK);
        @(negedge PCLK);
        if (will) begin
          check($sformatf("held_accept%0d_paddr", acc), 64'(PADDR), 64'(ha[acc]));
          acc++;
          if (acc < 6) begin
            cmd_write = hw[acc]; cmd_addr = ha[acc]; cmd_wdata = hd[acc];
          end else begin
            cmd_valid = 1'b0;
          end
        end
        if (rsp_valid) begin
          check($sformatf("held_rsp%0d_rdata", nrsp), 64'(rsp_rdata),
                64'(hw[nrsp] ? 32'h0 : hd[nrsp]));
          check($sformatf("held_rsp%0d_err", nrsp), 64'(rsp_err), 64'd0);
          nrsp++;
        end
      end
      cmd_valid = 1'b0;
      check("held_accept_count", 64'(acc), 64'd6);
      check("held_rsp_count", 64'(nrsp), 64'd6);
      for (int i = 0; i < 3; i++) ref_mem[ha[i]] = hd[i];
    end

    // Randomized transfers against the reference model
    for (int i = 0; i < 40; i++) begin
      logic        w;
      logic [31:0] a;
      logic [31:0] d;
      int          wt;
      logic        e_err;
      logic [31:0] e_rd;
      w  = 1'($urandom);
      a  = ($urandom % 2 == 0) ? 32'($urandom % 16) : 32'(32'hF0 + $urandom % 16);
      d  = $urandom;
      wt = $urandom_range(0, 4);
      e_err = (a >= 32'hF0);
      e_rd  = w ? 32'h0 : ref_read(a);
      if (w) ref_mem[a] = d;
      do_xfer(w, a, d, wt, lat, pen, err, rdata);
      check($sformatf("rnd%0d_latency", i), 64'(lat), 64'(3 + wt));
      check($sformatf("rnd%0d_err", i), 64'(err), 64'(e_err));
      check($sformatf("rnd%0d_rdata", i), 64'(rdata), 64'(e_rd));
      if ($urandom % 3 == 0) @(negedge PCLK);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
